// File: rtl/vedio_stream_rx_if.sv
// Video stream bundle: frame valid, line valid and pixel data.
// The source drives through the master modport, the receiver samples through slave.
interface vedio_stream_rx_if #(
  parameter int DW = 8
);
  logic          vsync;
  logic          hsync;
  logic [DW-1:0] data;

  modport master (output vsync, output hsync, output data);
  modport slave  (input  vsync, input  hsync, input  data);
endinterface

// File: rtl/vedio_stream_rx.sv
// Video stream receiver / link monitor.
// Frames the vsync/hsync/data stream, counts pixels per line and lines per frame,
// checks them against IW/IH, flags hsync protocol violations and sums the pixels of
// each frame. Results of a frame are published together with a one-cycle frame_done
// and held until the next frame closes.
module vedio_stream_rx #(
  parameter int DW     = 8,
  parameter int IW     = 640,
  parameter int IH     = 480,
  parameter int CW     = 32,
  parameter int FCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  vedio_stream_rx_if.slave  din,
  output logic              frame_done,
  output logic              frame_ok,
  output logic              err_width,
  output logic              err_height,
  output logic              err_sync,
  output logic [CW-1:0]     chksum,
  output logic [15:0]       line_num,
  output logic [FCNT_W-1:0] frame_cnt
);

  // Pixel counter is one bit wider than needed for IW so over-long lines are still
  // seen as wrong; it saturates instead of wrapping back onto IW.
  localparam int             PW      = $clog2(IW) + 1;
  localparam logic [PW-1:0]  PIX_MAX = '1;
  localparam logic [PW-1:0]  IW_P    = PW'(IW);
  localparam logic [15:0]    IH_L    = 16'(IH);
  localparam logic [15:0]    LINE_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    S_SYNC  = 2'd0,  // after reset: wait for a frame gap before trusting the stream
    S_WAIT  = 2'd1,  // between frames: working state cleared, waiting for vsync rise
    S_FRAME = 2'd2,  // inside a frame: counting and summing
    S_DONE  = 2'd3   // one cycle: publish results
  } state_t;

  state_t state, state_nxt;

  // Control strobes decoded from the state
  logic clr_work;
  logic run;
  logic publish;

  // Edge detection against the previous-cycle inputs
  logic vs_d, hs_d;
  logic vs_rise, vs_fall, hs_fall;

  // Working state of the frame in progress
  logic [DW-1:0] pix;
  logic [PW-1:0] pix_cnt;
  logic [PW-1:0] pix_next;
  logic [15:0]   line_cnt;
  logic [CW-1:0] acc;
  logic          w_err;
  logic          s_err;
  logic          first_cyc;
  logic          line_close;
  logic          h_err;

  assign pix     = din.data;
  assign vs_rise =  din.vsync & ~vs_d;
  assign vs_fall = ~din.vsync &  vs_d;
  assign hs_fall = ~din.hsync &  hs_d;
  assign h_err   = (line_cnt != IH_L);

  // Previous-cycle copies of the sync inputs, used only for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d <= 1'b0;
      hs_d <= 1'b0;
    end else begin
      // NOTE: registers are written with <= so every flop samples the values from
      // before the clock edge; a blocking = here would chain vs_d into later logic
      // within the same edge and simulate differently from the synthesized netlist.
      vs_d <= din.vsync;
      hs_d <= din.hsync;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_SYNC;
    else        state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    // NOTE: every combinational output gets a default before the case so that no
    // path leaves it unassigned; an unassigned path would infer a latch.
    state_nxt = state;
    case (state)
      S_SYNC:  if (!din.vsync) state_nxt = S_WAIT;
      S_WAIT:  if (vs_rise)    state_nxt = S_FRAME;
      S_FRAME: if (vs_fall)    state_nxt = S_DONE;
      S_DONE:                  state_nxt = S_WAIT;
      default:                 state_nxt = S_SYNC;
    endcase
  end

  // FSM output decode: which datapath action happens this cycle
  always_comb begin
    clr_work = 1'b0;
    run      = 1'b0;
    publish  = 1'b0;
    case (state)
      S_WAIT:  clr_work = 1'b1;
      S_FRAME: run      = 1'b1;
      S_DONE:  publish  = 1'b1;
      default: ;
    endcase
  end

  // Pixel count including the current cycle, and whether the open line ends now.
  // A line also ends when vsync falls with hsync still high; that last pixel is
  // sampled like any other and belongs to the closed line.
  always_comb begin
    pix_next = pix_cnt;
    if (din.hsync && (pix_cnt != PIX_MAX)) pix_next = pix_cnt + 1'b1;
    line_close = hs_fall | (vs_fall & din.hsync);
  end

  // Working counters, checksum accumulator and sticky error bits of the current frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt   <= '0;
      line_cnt  <= '0;
      acc       <= '0;
      w_err     <= 1'b0;
      s_err     <= 1'b0;
      first_cyc <= 1'b0;
    end else if (clr_work) begin
      pix_cnt   <= '0;
      line_cnt  <= '0;
      acc       <= '0;
      w_err     <= 1'b0;
      s_err     <= 1'b0;
      first_cyc <= 1'b1;
    end else if (run) begin
      first_cyc <= 1'b0;
      if (din.hsync) acc <= acc + CW'(pix);
      if (line_close) begin
        pix_cnt <= '0;
        if (line_cnt != LINE_MAX) line_cnt <= line_cnt + 16'd1;
        if (pix_next != IW_P)     w_err    <= 1'b1;
      end else begin
        pix_cnt <= pix_next;
      end
      // hsync already active when the frame opens, or still active when it closes
      if (din.hsync && (first_cyc || vs_fall)) s_err <= 1'b1;
    end
  end

  // Published results: updated only when a frame closes, held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      err_width  <= 1'b0;
      err_height <= 1'b0;
      err_sync   <= 1'b0;
      chksum     <= '0;
      line_num   <= '0;
      frame_cnt  <= '0;
    end else begin
      frame_done <= publish;
      if (publish) begin
        frame_ok   <= ~(w_err | h_err | s_err);
        err_width  <= w_err;
        err_height <= h_err;
        err_sync   <= s_err;
        chksum     <= acc;
        line_num   <= line_cnt;
        frame_cnt  <= frame_cnt + 1'b1;
      end
    end
  end

endmodule
